// File: rtl/ex_mul_div.sv
// ex_mul_div: iterative RV64M multiply/divide unit in the execute stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, one registered result beat.
module ex_mul_div #(
  parameter int W = 64
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [6:0]   OpCodeIn,
  input  logic [2:0]   Funct3In,
  input  logic [6:0]   Funct7In,
  input  logic [W-1:0] Rs1ReadDataIn,
  input  logic [W-1:0] Rs2ReadDataIn,
  input  logic [4:0]   RdAddrIn,
  input  logic         RdWriteEnableIn,
  input  logic         FlushIn,
  output logic         HoldFlagToCtrl,
  output logic         ResultValidOut,
  output logic [W-1:0] ResultOut,
  output logic [4:0]   RdAddrOut,
  output logic         RdWriteEnableOut
);
  localparam int HW = W / 2;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [6:0] OP_M  = 7'b0110011;
  localparam logic [6:0] OP_MW = 7'b0111011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [2:0]       f3_q, f3_d;
  logic             is_w_q, is_w_d;
  logic             neg_q, neg_d;
  logic [4:0]       rd_q, rd_d;
  logic [W-1:0]     result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             valid_q, valid_d;

  // Operand extension for the W variants: low half, sign- or zero-extended.
  function automatic logic [W-1:0] w_extend(input logic w, input logic sgn, input logic [W-1:0] v);
    logic [W-1:0] r;
    if (!w) r = v;
    else    r = {{HW{sgn & v[HW-1]}}, v[HW-1:0]};
    return r;
  endfunction

  function automatic logic [W-1:0] w_result(input logic w, input logic [W-1:0] v);
    return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  logic         is_w, start, a_signed, b_signed, sign_a, sign_b;
  logic         div_zero, div_ovf, neg_start;
  logic [W-1:0] a_ext, b_ext, mag_a, mag_b, most_neg, special_val;

  always_comb begin
    is_w        = (OpCodeIn == OP_MW);
    start       = RdWriteEnableIn && (Funct7In == 7'b0000001) &&
                  ((OpCodeIn == OP_M) || (is_w && ((Funct3In == 3'b000) || Funct3In[2])));
    a_signed    = Funct3In[2] ? ~Funct3In[0] : (Funct3In[1:0] != 2'b11);
    b_signed    = Funct3In[2] ? ~Funct3In[0] : ~Funct3In[1];
    a_ext       = w_extend(is_w, a_signed, Rs1ReadDataIn);
    b_ext       = w_extend(is_w, b_signed, Rs2ReadDataIn);
    sign_a      = a_signed & a_ext[W-1];
    sign_b      = b_signed & b_ext[W-1];
    mag_a       = sign_a ? -a_ext : a_ext;
    mag_b       = sign_b ? -b_ext : b_ext;
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    neg_start   = (Funct3In[2] && Funct3In[1]) ? sign_a : (sign_a ^ sign_b);
    most_neg    = is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    div_zero    = (b_ext == '0);
    div_ovf     = a_signed && (a_ext == most_neg) && (b_ext == '1);
    special_val = Funct3In[1] ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext);
  end

  logic [W:0]     mul_sum, div_trial, div_diff;
  logic [2*W-1:0] mul_next, prod_s;
  logic [W-1:0]   quo_next, rem_next, mul_sel, res_u, res_s, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    // Trial remainder is W+1 bits; bit W of the difference is the borrow.
    div_trial = {rem_q, acc_q[W-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    quo_next  = {acc_q[W-2:0], ~div_diff[W]};
    rem_next  = div_diff[W] ? div_trial[W-1:0] : div_diff[W-1:0];
    prod_s    = neg_q ? -mul_next : mul_next;
    mul_sel   = (f3_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    res_u     = f3_q[1] ? rem_next : quo_next;
    res_s     = neg_q ? -res_u : res_u;
    final_res = w_result(is_w_q, f3_q[2] ? res_s : mul_sel);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    is_w_d   = is_w_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d   = Funct3In;
          is_w_d = is_w;
          neg_d  = neg_start;
          rd_d   = RdAddrIn;
          cnt_d  = '0;
          acc_d  = {{W{1'b0}}, mag_a};
          rem_d  = '0;
          opb_d  = mag_b;
          if (!Funct3In[2]) begin
            state_d = S_MUL;
          end else if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = w_result(is_w, special_val);
            rd_out_d = RdAddrIn;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          acc_d = mul_next;
        end else begin
          acc_d = {acc_q[2*W-1:W], quo_next};
          rem_d = rem_next;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A kill abandons any operation in flight; the beat already in DONE still goes out.
    if (FlushIn) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    acc_q  <= acc_d;
    rem_q  <= rem_d;
    opb_q  <= opb_d;
    f3_q   <= f3_d;
    is_w_q <= is_w_d;
    neg_q  <= neg_d;
    rd_q   <= rd_d;
  end

  assign HoldFlagToCtrl   = Rst & (((state_q == S_IDLE) & start & ~FlushIn) |
                                   (state_q == S_MUL) | (state_q == S_DIV));
  assign ResultValidOut   = valid_q;
  assign RdWriteEnableOut = valid_q;
  assign ResultOut        = result_q;
  assign RdAddrOut        = rd_out_q;

endmodule

// File: tb/tb_ex_mul_div.sv
// Scoreboard bench for ex_mul_div: directed RV64M vectors with hand-computed results,
// hold/valid cycle timing, special-case divides, flush, reset and non-M instructions.
module tb_ex_mul_div;
  localparam logic [6:0] OP_M  = 7'b0110011;
  localparam logic [6:0] OP_MW = 7'b0111011;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [6:0]  OpCodeIn = '0;
  logic [2:0]  Funct3In = '0;
  logic [6:0]  Funct7In = '0;
  logic [63:0] Rs1ReadDataIn = '0;
  logic [63:0] Rs2ReadDataIn = '0;
  logic [4:0]  RdAddrIn = '0;
  logic        RdWriteEnableIn = 1'b0;
  logic        FlushIn = 1'b0;
  logic        HoldFlagToCtrl;
  logic        ResultValidOut;
  logic [63:0] ResultOut;
  logic [4:0]  RdAddrOut;
  logic        RdWriteEnableOut;

  ex_mul_div #(.W(64)) dut (
    .Clk(Clk), .Rst(Rst), .OpCodeIn(OpCodeIn), .Funct3In(Funct3In), .Funct7In(Funct7In),
    .Rs1ReadDataIn(Rs1ReadDataIn), .Rs2ReadDataIn(Rs2ReadDataIn), .RdAddrIn(RdAddrIn),
    .RdWriteEnableIn(RdWriteEnableIn), .FlushIn(FlushIn), .HoldFlagToCtrl(HoldFlagToCtrl),
    .ResultValidOut(ResultValidOut), .ResultOut(ResultOut), .RdAddrOut(RdAddrOut),
    .RdWriteEnableOut(RdWriteEnableOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst && ResultValidOut) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual %h rd %0d required no result", ResultOut, RdAddrOut);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, ResultOut, e.res);
        chk({e.name, "_rd"}, 64'(RdAddrOut), 64'(e.rd));
        chk({e.name, "_wen"}, 64'(RdWriteEnableOut), 64'd1);
      end
    end
  end

  task automatic nop();
    OpCodeIn = 7'b0010011;
    Funct3In = '0;
    Funct7In = '0;
    Rs1ReadDataIn = '0;
    Rs2ReadDataIn = '0;
    RdAddrIn = '0;
    RdWriteEnableIn = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    OpCodeIn = op;
    Funct3In = f3;
    Funct7In = 7'b0000001;
    Rs1ReadDataIn = a;
    Rs2ReadDataIn = b;
    RdAddrIn = rd;
    RdWriteEnableIn = 1'b1;
  endtask

  // Called just after a falling edge: presents the op as cycle 0 and keeps it while held.
  task automatic run_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_res, input int exp_hold);
    int hc;
    logic early;
    drive(op, f3, a, b, rd);
    sb.push_back('{res: exp_res, rd: rd, name: name});
    hc = 0;
    early = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!HoldFlagToCtrl) break;
      if (ResultValidOut) early = 1'b1;
      hc++;
      @(negedge Clk);
    end
    chk({name, "_hold_cycles"}, 64'(hc), 64'(exp_hold));
    chk({name, "_early_valid"}, 64'(early), 64'd0);
    chk({name, "_valid_beat"}, 64'(ResultValidOut), 64'd1);
    nop();
  endtask

  task automatic idle_check(input string name, input int ncyc);
    int hc;
    int vc;
    hc = 0;
    vc = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (HoldFlagToCtrl) hc++;
      if (ResultValidOut) vc++;
      @(negedge Clk);
    end
    chk({name, "_hold"}, 64'(hc), 64'd0);
    chk({name, "_valid"}, 64'(vc), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    #2 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    drive(OP_M, 3'b000, 64'd3, 64'd4, 5'd1);
    #1;
    chk("rst_hold_gated", 64'(HoldFlagToCtrl), 64'd0);
    chk("rst_result", ResultOut, 64'd0);
    chk("rst_rd", 64'(RdAddrOut), 64'd0);
    chk("rst_valid", 64'(ResultValidOut), 64'd0);
    chk("rst_wen", 64'(RdWriteEnableOut), 64'd0);
    nop();
    @(negedge Clk);
    Rst = 1'b1;
    idle_check("idle_after_rst", 2);

    run_op("mul", OP_M, 3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    @(negedge Clk);
    #1;
    chk("result_held", ResultOut, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("valid_single", 64'(ResultValidOut), 64'd0);
    run_op("mulhu", OP_M, 3'b011, '1, '1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    @(negedge Clk);
    run_op("mulh", OP_M, 3'b001, '1, '1, 5'd9, 64'd0, 65);
    @(negedge Clk);
    run_op("mulhsu", OP_M, 3'b010, '1, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    @(negedge Clk);
    run_op("divu_by0", OP_M, 3'b101, 64'd7, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    @(negedge Clk);
    run_op("rem_by0", OP_M, 3'b110, 64'd7, 64'd0, 5'd12, 64'd7, 1);
    @(negedge Clk);
    run_op("div_ovf", OP_M, 3'b100, 64'h8000_0000_0000_0000, '1, 5'd13, 64'h8000_0000_0000_0000, 1);
    @(negedge Clk);
    run_op("rem_ovf", OP_M, 3'b110, 64'h8000_0000_0000_0000, '1, 5'd14, 64'd0, 1);
    @(negedge Clk);
    run_op("divw_ovf", OP_MW, 3'b100, 64'h0000_0000_8000_0000, '1, 5'd15, 64'hFFFF_FFFF_8000_0000, 1);
    @(negedge Clk);
    run_op("divw", OP_MW, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    @(negedge Clk);
    run_op("remw", OP_MW, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    @(negedge Clk);
    run_op("mulw", OP_MW, 3'b000, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    @(negedge Clk);
    run_op("div_neg", OP_M, 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd19, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    @(negedge Clk);
    run_op("remu", OP_M, 3'b111, 64'd100, 64'd7, 5'd20, 64'd2, 65);
    @(negedge Clk);
    run_op("divuw", OP_MW, 3'b101, 64'hFFFF_FFFF_0000_0064, 64'd7, 5'd21, 64'd14, 65);

    // Flush in cycle 20 of a divide.
    @(negedge Clk);
    drive(OP_M, 3'b101, 64'd100, 64'd7, 5'd22);
    repeat (20) @(negedge Clk);
    #1;
    chk("flush_hold_c20", 64'(HoldFlagToCtrl), 64'd1);
    FlushIn = 1'b1;
    @(negedge Clk);
    FlushIn = 1'b0;
    nop();
    #1;
    chk("flush_hold_c21", 64'(HoldFlagToCtrl), 64'd0);
    idle_check("flush_quiet", 70);
    run_op("after_flush", OP_M, 3'b111, 64'd100, 64'd7, 5'd23, 64'd2, 65);

    // Reset in cycle 30 of a multiply, with the start left presented.
    @(negedge Clk);
    drive(OP_M, 3'b000, 64'd3, 64'd5, 5'd24);
    repeat (30) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("midrst_result", ResultOut, 64'd0);
    chk("midrst_rd", 64'(RdAddrOut), 64'd0);
    chk("midrst_valid", 64'(ResultValidOut), 64'd0);
    chk("midrst_wen", 64'(RdWriteEnableOut), 64'd0);
    chk("midrst_hold", 64'(HoldFlagToCtrl), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    run_op("mul_after_rst", OP_M, 3'b000, 64'd6, 64'd7, 5'd25, 64'd42, 65);

    // Instructions that must not start the unit.
    @(negedge Clk);
    drive(OP_M, 3'b000, 64'd5, 64'd6, 5'd3);
    Funct7In = 7'b0000000;
    idle_check("add_ignored", 5);
    drive(OP_MW, 3'b001, 64'd5, 64'd6, 5'd3);
    idle_check("mw_f3_001_ignored", 5);
    drive(OP_M, 3'b000, 64'd5, 64'd6, 5'd3);
    RdWriteEnableIn = 1'b0;
    idle_check("no_wen_ignored", 5);
    nop();

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mul_div.md
# ex_mul_div

Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the decoded opcode, funct fields, operands and destination info from that register. It stalls the front of the pipe through the control unit's hold path while it computes, then presents one result beat toward EX/MEM write-back. Non-M instructions are ignored and handled by the ordinary ALU.

## Interface
- `W`, 64, datapath width; must be even; the W-variant half-width is `W/2`.
- `Clk`  in  1  pipeline clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `OpCodeIn`  in  7  opcode from ID/EX.
- `Funct3In`  in  3  funct3 from ID/EX.
- `Funct7In`  in  7  funct7 from ID/EX.
- `Rs1ReadDataIn`  in  W  operand A.
- `Rs2ReadDataIn`  in  W  operand B.
- `RdAddrIn`  in  5  destination register.
- `RdWriteEnableIn`  in  1  instruction-valid/write qualifier.
- `FlushIn`  in  1  jump/branch kill from control.
- `HoldFlagToCtrl`  out  1  stall request; control ORs it into the ID/EX and upstream hold.
- `ResultValidOut`  out  1  one-cycle result strobe.
- `ResultOut`  out  W  result value.
- `RdAddrOut`  out  5  destination of the result.
- `RdWriteEnableOut`  out  1  equals `ResultValidOut`.

## Operation
- Start condition: `RdWriteEnableIn`, `Funct7In==7'b0000001`, and one of:
  - `OpCodeIn==7'b0110011` (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, selected by funct3);
  - `OpCodeIn==7'b0111011` with funct3 in {000, 100, 101, 110, 111} (MULW, DIVW, DIVUW, REMW, REMUW).
- Other funct3 values under 0111011 do not start.
- A start is accepted only in IDLE with `FlushIn` low.
- States: IDLE, MUL, DIV, DONE.
  - IDLE→MUL: start with funct3[2]=0.
  - IDLE→DIV: start with funct3[2]=1 and no special case.
  - IDLE→DONE: divide special case.
  - MUL/DIV→DONE: iteration counter reaches W−1.
  - DONE→IDLE: always.
  - Any state→IDLE: `FlushIn`. No result is produced, and flush beats start in the same cycle.
- On accept, latch operands, funct3, the W-flag, `RdAddrIn`, and the sign-fix flags.
- W variants operate on operand bits [W/2−1:0]:
  - sign-extended for signed ops, zero-extended for unsigned ops;
  - the final result is bits [W/2−1:0] sign-extended to W.
- Signed ops convert operands to magnitudes. The core is unsigned. The result is negated at DONE when required:
  - product: sign A XOR sign B;
  - quotient: sign A XOR sign B;
  - remainder: sign A.
- MUL is shift-add, 1 bit/cycle, W cycles, with a 2W-bit accumulator.
  - MUL/MULW return the low W bits (MULW truncated per the rule above).
  - MULH/MULHSU/MULHU return the high W bits.
  - MULHSU treats only A as signed.
- DIV is restoring, 1 quotient bit/cycle, W cycles, with a W+1-bit partial remainder. W variants still iterate W cycles on extended operands.
- Special cases resolve in one cycle:
  - divisor 0: quotient = all ones, remainder = dividend (after W-extension);
  - signed overflow (most-negative ÷ −1, at the operative width): quotient = dividend, remainder = 0.
- `HoldFlagToCtrl` = (IDLE & start & ~FlushIn) | MUL | DIV. It is combinational and forced 0 while `Rst` is low.
- DONE drives:
  - `ResultValidOut=1` and `RdWriteEnableOut=1`;
  - `ResultOut` = final value;
  - `RdAddrOut` = latched rd.
- Hold is low in DONE, so ID/EX advances on that edge. The same instruction is never restarted.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `ResultOut` 0, `RdAddrOut` 0;
  - `ResultValidOut` 0, `RdWriteEnableOut` 0, `HoldFlagToCtrl` 0.
- Cycle numbering: cycle 0 is the cycle a start is presented in IDLE. Hold is high in cycle 0.
- MUL/DIV: hold is high in cycles 0..W (65 cycles at W=64). DONE and the result beat occur in cycle W+1.
- Special-case divide: hold is high in cycle 0 only. The result beat occurs in cycle 1.
- Outputs are registered. `ResultOut` and `RdAddrOut` hold their value after DONE until the next DONE. `ResultValidOut` is a single-cycle pulse.
- Back-to-back M ops: the next start is accepted in the IDLE cycle after DONE, giving a 1-cycle bubble.
- `Rst` asserted mid-operation: immediate return to reset values with no result. Rst deasserted with a start presented: the start is accepted on the first edge after release.
- Flush in DONE does not suppress the already-registered result beat of that cycle.

## Test plan
- MUL 3 × 0xFFFF_FFFF_FFFF_FFFB → hold high cycles 0–64; `ResultValidOut` high only in cycle 65; `ResultOut`=0xFFFF_FFFF_FFFF_FFF1; `RdAddrOut`=rd.
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULH same operands → 0. MULHSU −1 × 2 → all ones.
- DIVU 7 ÷ 0 → all ones, and REM 7 ÷ 0 → 7, each with hold high only in cycle 0 and valid in cycle 1.
- DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000, and REM → 0, both in cycle 1. DIVW 0x8000_0000 ÷ −1 → 0xFFFF_FFFF_8000_0000.
- DIVW −7 ÷ 2 → 0xFFFF_FFFF_FFFF_FFFD, and REMW → all ones, each in cycle 65. MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- Three interruption cases:
  - `FlushIn` in cycle 20 of a DIV → hold low from cycle 21, no valid pulse, next op accepted;
  - `Rst` low in cycle 30 → all outputs 0 at once;
  - non-M op (ADD, `Funct7In`=0) → hold and valid stay 0.
